// File: rtl/regfile_alu_pipe.sv
// Register file feeding a two-stage ALU pipeline (X = operand stage,
// R = output stage) with writeback on X->R transfer and a read-after-write
// bypass so dependent instructions can issue back to back.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready does not depend on in_valid. out_valid never drops
// and res/carryout/zero/out_rd never change while out_ready is low.
module regfile_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic [2:0]       in_oper,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_wb,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carryout,
  output logic             zero,
  output logic [AW-1:0]    out_rd
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_SHR1 = 3'b111;

  logic [WIDTH-1:0] regs [NREGS];

  // X stage
  logic             x_full;
  logic [WIDTH-1:0] x_a;
  logic [WIDTH-1:0] x_b;
  logic [2:0]       x_op;
  logic             x_load;
  logic             x_wb;
  logic [AW-1:0]    x_rd;
  logic [WIDTH-1:0] x_imm;

  // R stage
  logic             r_full;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_zero;
  logic [AW-1:0]    r_rd;

  logic             x_adv;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             wb_now;

  assign x_adv    = x_full && (!r_full || out_ready);
  assign in_ready = !x_full || x_adv;
  assign accept   = in_valid && in_ready;
  assign wb_now   = x_adv && x_wb;

  assign out_valid = r_full;
  assign res       = r_res;
  assign carryout  = r_carry;
  assign zero      = r_zero;
  assign out_rd    = r_rd;

  // ALU on the X-stage operands; a load simply forwards the immediate
  always_comb begin
    logic [WIDTH:0] wide;
    wide      = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    if (x_load) begin
      alu_res = x_imm;
    end else begin
      case (x_op)
        OP_ADD: begin
          wide      = {1'b0, x_a} + {1'b0, x_b};
          alu_res   = wide[WIDTH-1:0];
          alu_carry = wide[WIDTH];
        end
        OP_SUB: begin
          // Borrow falls out as the top bit of the widened difference
          wide      = {1'b0, x_a} - {1'b0, x_b};
          alu_res   = wide[WIDTH-1:0];
          alu_carry = wide[WIDTH];
        end
        OP_AND:  alu_res = x_a & x_b;
        OP_OR:   alu_res = x_a | x_b;
        OP_XOR:  alu_res = x_a ^ x_b;
        OP_PASS: alu_res = x_a;
        OP_SHL1: begin
          alu_res   = {x_a[WIDTH-2:0], 1'b0};
          alu_carry = x_a[WIDTH-1];
        end
        OP_SHR1: begin
          alu_res   = {1'b0, x_a[WIDTH-1:1]};
          alu_carry = x_a[0];
        end
        default: alu_res = '0;
      endcase
    end
  end

  // Operand read with bypass of the result being written on this same edge
  always_comb begin
    op_a = regs[in_rs1];
    op_b = regs[in_rs2];
    if (wb_now && (in_rs1 == x_rd)) op_a = alu_res;
    if (wb_now && (in_rs2 == x_rd)) op_b = alu_res;
  end

  // Register file: written only when an instruction leaves X with wb set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_now) begin
      regs[x_rd] <= alu_res;
    end
  end

  // X stage: capture operands at acceptance, empty when it advances alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_full <= 1'b0;
      x_a    <= '0;
      x_b    <= '0;
      x_op   <= '0;
      x_load <= 1'b0;
      x_wb   <= 1'b0;
      x_rd   <= '0;
      x_imm  <= '0;
    end else if (accept) begin
      x_full <= 1'b1;
      x_a    <= op_a;
      x_b    <= op_b;
      x_op   <= in_oper;
      x_load <= in_load;
      x_wb   <= in_wb;
      x_rd   <= in_rd;
      x_imm  <= in_data;
    end else if (x_adv) begin
      x_full <= 1'b0;
    end
  end

  // R stage: loads from X, drops its valid once the consumer takes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full  <= 1'b0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_rd    <= '0;
    end else if (x_adv) begin
      r_full  <= 1'b1;
      r_res   <= alu_res;
      r_carry <= alu_carry;
      r_zero  <= (alu_res == '0);
      r_rd    <= x_rd;
    end else if (r_full && out_ready) begin
      r_full  <= 1'b0;
    end
  end

endmodule
